lb_seq: RTL and testbench

LB_SEQ -- requirements
Module: lb_seq

---
 rtl/lb_seq.sv | 124 ++++++++++++
 tb/tb_lb_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_seq.sv
// lb_seq: line-buffer sequencer for a ping-pong pair of line buffers.
// The display side restarts on every LINE_START, flips the bank select and
// walks DISP_X across the visible line while enabling clear-after-read on the
// display bank. The render side accepts one sprite request at a time, loads
// the render bank address, then issues one write strobe per pixel strobe.
// Bank polarity: TMS0=1 puts pair 1 on display and pair 2 on render,
// TMS0=0 puts pair 2 on display and pair 1 on render.
module lb_seq #(
    parameter int LINE_PIX = 320
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       PIX_EN,
    input  logic       LINE_START,
    input  logic       VBLANK,
    input  logic       SPR_VALID,
    input  logic [7:0] SPR_X,
    input  logic [3:0] SPR_LEN,
    output logic       SPR_READY,
    output logic       TMS0,
    output logic       LD1,
    output logic       LD2,
    output logic       SS1,
    output logic       SS2,
    output logic [7:0] LB_ADDR,
    output logic       WE_R,
    output logic [7:0] OVR_CNT
);

    localparam logic [8:0] LINE_END = 9'(LINE_PIX);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

    state_t     state;
    state_t     state_nx;
    logic       line_start_p0;
    logic       tms0_nx;
    logic [8:0] disp_x;
    logic [8:0] disp_x_nx;
    logic [3:0] rem;
    logic       accept;
    logic       abort;

    // Next-state values shared by the display and render registers
    always_comb begin
        tms0_nx   = line_start_p0 ? ~TMS0 : TMS0;
        disp_x_nx = disp_x;
        if (line_start_p0)
            disp_x_nx = '0;
        else if (PIX_EN && (disp_x < LINE_END))
            disp_x_nx = disp_x + 9'd1;

        // A handshake that collides with a new line is dropped: the bank it
        // was aimed at is about to become the display bank.
        accept = SPR_VALID & SPR_READY & ~LINE_START;
        abort  = LINE_START & (state != IDLE);

        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = LOAD;
            LOAD:    state_nx = abort ? IDLE : WRITE;
            WRITE:   if (abort || (PIX_EN && (rem == 4'd0))) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Display side: bank flip, display pixel counter and clear-after-read enables
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            line_start_p0 <= 1'b0;
            TMS0          <= 1'b0;
            disp_x        <= LINE_END;
            SS1           <= 1'b0;
            SS2           <= 1'b0;
        end else begin
            line_start_p0 <= LINE_START;
            TMS0          <= tms0_nx;
            disp_x        <= disp_x_nx;
            SS1           <= (disp_x_nx < LINE_END) & ~VBLANK & tms0_nx;
            SS2           <= (disp_x_nx < LINE_END) & ~VBLANK & ~tms0_nx;
        end
    end

    // Render FSM with registered handshake, load strobes, write strobe and abort count
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            rem       <= 4'd0;
            SPR_READY <= 1'b0;
            LD1       <= 1'b0;
            LD2       <= 1'b0;
            LB_ADDR   <= 8'h00;
            WE_R      <= 1'b0;
            OVR_CNT   <= 8'h00;
        end else begin
            state     <= state_nx;
            // Ready is withheld on a LINE_START edge so that the display load
            // issued on the following edge never meets a render load.
            SPR_READY <= (state_nx == IDLE) & ~VBLANK & ~LINE_START;
            WE_R      <= (state == WRITE) & PIX_EN & ~LINE_START;
            LD1       <= 1'b0;
            LD2       <= 1'b0;

            if (line_start_p0) begin
                LB_ADDR <= 8'h00;
                LD1     <= tms0_nx;
                LD2     <= ~tms0_nx;
            end else if (accept) begin
                // The render bank is fixed here by TMS0 at accept time.
                LB_ADDR <= SPR_X;
                LD1     <= ~TMS0;
                LD2     <= TMS0;
                rem     <= SPR_LEN;
            end

            if ((state == WRITE) && PIX_EN && !LINE_START && (rem != 4'd0))
                rem <= rem - 4'd1;

            if (abort && (OVR_CNT != 8'hFF))
                OVR_CNT <= OVR_CNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_lb_seq.sv
// tb_lb_seq: table-driven render requests plus hand-written line, abort,
// blanking and reset sequences. Expected load strobes go into a scoreboard
// queue when stimulus is driven and are matched as the DUT emits them.
module tb_lb_seq;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       PIX_EN = 1'b0;
    logic       LINE_START = 1'b0;
    logic       VBLANK = 1'b0;
    logic       SPR_VALID = 1'b0;
    logic [7:0] SPR_X = 8'h00;
    logic [3:0] SPR_LEN = 4'h0;
    logic       SPR_READY, TMS0, LD1, LD2, SS1, SS2, WE_R;
    logic [7:0] LB_ADDR, OVR_CNT;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_tms0 = 1'b0;

    typedef struct packed {
        logic       ld2;
        logic [7:0] addr;
    } ld_t;
    ld_t ld_q[$];

    typedef struct {
        logic [7:0] x;
        logic [3:0] len;
        bit         hold;
        bit         vb_mid;
        int         exp_wr;
    } vec_t;
    vec_t vecs[6];

    lb_seq #(.LINE_PIX(320)) dut (
        .CLK(CLK), .nRST(nRST), .PIX_EN(PIX_EN), .LINE_START(LINE_START),
        .VBLANK(VBLANK), .SPR_VALID(SPR_VALID), .SPR_X(SPR_X), .SPR_LEN(SPR_LEN),
        .SPR_READY(SPR_READY), .TMS0(TMS0), .LD1(LD1), .LD2(LD2), .SS1(SS1),
        .SS2(SS2), .LB_ADDR(LB_ADDR), .WE_R(WE_R), .OVR_CNT(OVR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Every load strobe must match the next queued expectation, one CLK each
    always @(negedge CLK) begin
        if (nRST) begin
            if (LD1 && LD2) chk("ld_exclusive", 32'({LD1, LD2}), 32'b10);
            else if (LD1 || LD2) begin
                if (ld_q.size() == 0) chk("ld_unexpected", 32'({LD2, LB_ADDR}), 32'h1FF_FFFF);
                else chk("ld_bank_addr", 32'({LD2, LB_ADDR}), 32'(ld_q.pop_front()));
            end
        end
    end

    task automatic line_start();
        exp_tms0 = ~exp_tms0;
        ld_q.push_back('{ld2: ~exp_tms0, addr: 8'h00});
        LINE_START = 1'b1;
        tick();
        LINE_START = 1'b0;
        tick();
        chk("tms0_toggle", 32'(TMS0), 32'(exp_tms0));
    endtask

    task automatic accept_req(input logic [7:0] x, input logic [3:0] len, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (SPR_READY) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            chk("ready_wait_timeout", 32'(SPR_READY), 32'd1);
            return;
        end
        ld_q.push_back('{ld2: exp_tms0, addr: x});
        SPR_VALID = 1'b1;
        SPR_X     = x;
        SPR_LEN   = len;
        tick();
        SPR_VALID = 1'b0;
        chk("ready_low_after_accept", 32'(SPR_READY), 32'd0);
    endtask

    task automatic do_req(input vec_t v, output int writes, output int span);
        bit ok;
        int first;
        int last;
        writes = 0;
        first  = -1;
        last   = -1;
        accept_req(v.x, v.len, ok);
        for (int c = 0; c < 56; c++) begin
            PIX_EN = v.hold ? 1'b1 : (c % 3 == 0);
            tick();
            if (WE_R) begin
                writes++;
                if (first < 0) first = c;
                last = c;
                if (v.vb_mid) VBLANK = 1'b1;
            end
        end
        PIX_EN = 1'b0;
        VBLANK = 1'b0;
        tick();
        tick();
        span = (first < 0) ? 0 : last - first + 1;
    endtask

    initial begin
        int   wr;
        int   sp;
        int   cnt;
        bit   ok;

        vecs[0] = '{x: 8'h40, len: 4'd3,  hold: 1'b0, vb_mid: 1'b0, exp_wr: 4};
        vecs[1] = '{x: 8'h00, len: 4'd0,  hold: 1'b1, vb_mid: 1'b0, exp_wr: 1};
        vecs[2] = '{x: 8'hFF, len: 4'd15, hold: 1'b1, vb_mid: 1'b0, exp_wr: 16};
        vecs[3] = '{x: 8'h7A, len: 4'd9,  hold: 1'b0, vb_mid: 1'b0, exp_wr: 10};
        vecs[4] = '{x: 8'h12, len: 4'd5,  hold: 1'b1, vb_mid: 1'b1, exp_wr: 6};
        vecs[5] = '{x: 8'hC3, len: 4'd3,  hold: 1'b0, vb_mid: 1'b1, exp_wr: 4};

        // Reset values before any clock edge
        #3;
        chk("rst_tms0", 32'(TMS0), 32'd0);
        chk("rst_ld", 32'({LD1, LD2}), 32'd0);
        chk("rst_ss", 32'({SS1, SS2}), 32'd0);
        chk("rst_we_ready", 32'({WE_R, SPR_READY}), 32'd0);
        chk("rst_addr", 32'(LB_ADDR), 32'd0);
        chk("rst_ovr", 32'(OVR_CNT), 32'd0);

        tick();
        nRST = 1'b1;
        tick();
        chk("ready_after_release", 32'(SPR_READY), 32'd1);

        // First line: pair 1 displays, SS1 spans exactly 320 pixel strobes
        line_start();
        chk("ss1_line_begin", 32'({SS1, SS2}), 32'b10);
        chk("ovr_idle_line_start", 32'(OVR_CNT), 32'd0);
        cnt = 0;
        sp  = 0;
        for (int c = 0; c < 700; c++) begin
            PIX_EN = (c % 2 == 0);
            if (PIX_EN && SS1) cnt++;
            if (SS2) sp++;
            tick();
        end
        PIX_EN = 1'b0;
        chk("ss1_pixel_count", 32'(cnt), 32'd320);
        chk("ss1_after_line", 32'(SS1), 32'd0);
        chk("ss2_never_high", 32'(sp), 32'd0);

        // Table of render requests with TMS0=1 (pair 2 renders)
        foreach (vecs[i]) begin
            do_req(vecs[i], wr, sp);
            chk($sformatf("writes_vec%0d", i), 32'(wr), 32'(vecs[i].exp_wr));
            if (vecs[i].hold) chk($sformatf("consecutive_vec%0d", i), 32'(sp), 32'(vecs[i].exp_wr));
            chk($sformatf("ready_done_vec%0d", i), 32'(SPR_READY), 32'd1);
            chk($sformatf("we_quiet_vec%0d", i), 32'(WE_R), 32'd0);
        end

        // Flip banks: pair 1 now renders
        line_start();
        do_req('{x: 8'h33, len: 4'd2, hold: 1'b0, vb_mid: 1'b0, exp_wr: 3}, wr, sp);
        chk("writes_pair1", 32'(wr), 32'd3);

        // Abort after the 2nd write of an 8-pair request
        accept_req(8'h20, 4'd7, ok);
        wr = 0;
        for (int c = 0; c < 40 && wr < 2; c++) begin
            PIX_EN = (c % 2 == 0);
            tick();
            if (WE_R) wr++;
        end
        chk("abort_two_writes", 32'(wr), 32'd2);
        exp_tms0 = ~exp_tms0;
        ld_q.push_back('{ld2: ~exp_tms0, addr: 8'h00});
        LINE_START = 1'b1;
        PIX_EN     = 1'b1;
        tick();
        LINE_START = 1'b0;
        chk("abort_we_suppressed", 32'(WE_R), 32'd0);
        tick();
        chk("abort_tms0", 32'(TMS0), 32'(exp_tms0));
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (WE_R) cnt++;
        end
        PIX_EN = 1'b0;
        chk("abort_no_more_we", 32'(cnt), 32'd0);
        chk("abort_ovr_one", 32'(OVR_CNT), 32'd1);

        // Blanking: no handshake, no clear enables, no writes
        line_start();
        VBLANK = 1'b1;
        tick();
        SPR_VALID = 1'b1;
        SPR_X     = 8'h55;
        SPR_LEN   = 4'd1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            PIX_EN = (c % 2 == 0);
            tick();
            if (SPR_READY || SS1 || SS2 || WE_R) cnt++;
        end
        PIX_EN    = 1'b0;
        SPR_VALID = 1'b0;
        tick();
        VBLANK = 1'b0;
        tick();
        chk("vblank_quiet", 32'(cnt), 32'd0);
        chk("ss_after_vblank", 32'({SS1, SS2}), exp_tms0 ? 32'b10 : 32'b01);
        chk("ready_after_vblank", 32'(SPR_READY), 32'd1);

        // 300 more aborted requests saturate the counter
        for (int i = 0; i < 300; i++) begin
            accept_req(8'(i), 4'd15, ok);
            tick();
            tick();
            line_start();
        end
        chk("ovr_saturated", 32'(OVR_CNT), 32'hFF);

        // Asynchronous reset in the middle of a write burst
        accept_req(8'h10, 4'd15, ok);
        PIX_EN = 1'b1;
        wr = 0;
        for (int c = 0; c < 10 && wr < 3; c++) begin
            tick();
            if (WE_R) wr++;
        end
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst_outputs", 32'({TMS0, LD1, LD2, SS1, SS2, WE_R, SPR_READY}), 32'd0);
        chk("midrst_addr_ovr", 32'({LB_ADDR, OVR_CNT}), 32'd0);
        tick();
        tick();
        nRST     = 1'b1;
        exp_tms0 = 1'b0;
        tick();
        chk("ready_after_midrst", 32'(SPR_READY), 32'd1);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (WE_R) cnt++;
        end
        PIX_EN = 1'b0;
        chk("midrst_no_we", 32'(cnt), 32'd0);
        chk("midrst_ovr", 32'(OVR_CNT), 32'd0);

        tick();
        chk("ld_queue_drained", 32'(ld_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
